// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two 2-entry {dest, data} queues (ALU, load)
// merged onto one registered write port, load-first with an anti-starvation streak.

module regfile_wb_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic [36:0] din_i,
    input  logic        pop_i,
    output logic [36:0] head_o,
    output logic [1:0]  cnt_o
);
    logic [1:0][36:0] slot_q, slot_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    // Callers only push when not full and only pop when not empty.
    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            slot_d[wr_ptr_q] = din_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o = slot_q[rd_ptr_q];
    assign cnt_o  = cnt_q;
endmodule

module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_dest,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_data,
    output logic        reg_write,
    output logic [4:0]  write,
    output logic [31:0] write_data,
    output logic [2:0]  pending
);
    // Handshake: a beat transfers at a rising edge when valid && ready. ready
    // depends only on registered occupancy, so a same-cycle pop never raises it.
    logic        run_q;
    logic [1:0]  alu_cnt, mem_cnt;
    logic [36:0] alu_head, mem_head;
    logic        alu_push, mem_push;
    logic        alu_ne, mem_ne;
    logic        grant_alu, grant_mem;
    logic [1:0]  streak_q, streak_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_q, write_d;
    logic [31:0] write_data_q, write_data_d;

    assign alu_ready = run_q && (alu_cnt != 2'd2);
    assign mem_ready = run_q && (mem_cnt != 2'd2);

    // Beats aimed at r0 are accepted and dropped.
    assign alu_push = alu_valid && alu_ready && (alu_dest != 5'd0);
    assign mem_push = mem_valid && mem_ready && (mem_dest != 5'd0);

    regfile_wb_fifo u_alu_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (alu_push),
        .din_i  ({alu_dest, alu_data}),
        .pop_i  (grant_alu),
        .head_o (alu_head),
        .cnt_o  (alu_cnt)
    );

    regfile_wb_fifo u_mem_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (mem_push),
        .din_i  ({mem_dest, mem_data}),
        .pop_i  (grant_mem),
        .head_o (mem_head),
        .cnt_o  (mem_cnt)
    );

    assign alu_ne = (alu_cnt != 2'd0);
    assign mem_ne = (mem_cnt != 2'd0);

    // Loads win unless three loads in a row have already passed a waiting ALU beat.
    always_comb begin
        grant_alu = alu_ne && (!mem_ne || (streak_q == 2'd3));
        grant_mem = mem_ne && !grant_alu;
        if (!alu_ne || grant_alu) begin
            streak_d = 2'd0;
        end else if (grant_mem) begin
            streak_d = streak_q + 2'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    always_comb begin
        reg_write_d  = grant_alu || grant_mem;
        write_d      = write_q;
        write_data_d = write_data_q;
        if (grant_alu) begin
            {write_d, write_data_d} = alu_head;
        end else if (grant_mem) begin
            {write_d, write_data_d} = mem_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            streak_q     <= 2'd0;
            reg_write_q  <= 1'b0;
            write_q      <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            run_q        <= 1'b1;
            streak_q     <= streak_d;
            reg_write_q  <= reg_write_d;
            write_q      <= write_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write      = write_q;
    assign write_data = write_data_q;
    assign pending    = {1'b0, alu_cnt} + {1'b0, mem_cnt};
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change and outputs are sampled
// on the falling edge; every write seen is logged and compared against hand-built orders.

module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  write;
  logic [31:0] write_data;
  logic [2:0]  pending;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_dest   (alu_dest),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .reg_write  (reg_write),
    .write      (write),
    .write_data (write_data),
    .pending    (pending)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor
  always @(negedge clk) begin
    if (rst_n && reg_write) got_q.push_back({write, write_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_seq%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  // Streams na ALU beats (dest abase+i, data A00+i) and nm load beats
  // (dest mbase+i, data B00+i), each valid held high until all are accepted.
  task automatic run_stream(input int na, input int nm, input logic [4:0] abase,
                            input logic [4:0] mbase, input bit chk_full);
    int ia = 0;
    int im = 0;
    int n  = 0;
    logic ar, mr;
    alu_valid = (na > 0); alu_dest = abase; alu_data = 32'hA00;
    mem_valid = (nm > 0); mem_dest = mbase; mem_data = 32'hB00;
    while ((ia < na || im < nm) && n < 60) begin
      ar = alu_ready;
      mr = mem_ready;
      @(negedge clk);
      n++;
      if (alu_valid && ar) begin
        ia++;
        if (chk_full && ia == 2) chk("alu_ready_full", 64'(alu_ready), 64'd0);
        if (ia == na) alu_valid = 1'b0;
        alu_dest = abase + 5'(ia);
        alu_data = 32'hA00 + 32'(ia);
      end
      if (mem_valid && mr) begin
        im++;
        if (im == nm) mem_valid = 1'b0;
        mem_dest = mbase + 5'(im);
        mem_data = 32'hB00 + 32'(im);
      end
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    if (ia < na || im < nm) chk("stream_timeout", 64'd0, 64'd1);
    cyc(12);
  endtask

  task automatic exp_alu(input int i, input logic [4:0] abase);
    exp_q.push_back({abase + 5'(i), 32'hA00 + 32'(i)});
  endtask

  task automatic exp_mem(input int i, input logic [4:0] mbase);
    exp_q.push_back({mbase + 5'(i), 32'hB00 + 32'(i)});
  endtask

  initial begin
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;

    // reset without any clock edge
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("post_rst_mem_ready", 64'(mem_ready), 64'd1);

    // single ALU beat: dest 7, data 1
    alu_valid = 1; alu_dest = 5'd7; alu_data = 32'h1;
    cyc(1);
    alu_valid = 0;
    chk("single_pending", 64'(pending), 64'd1);
    chk("single_no_early_write", 64'(reg_write), 64'd0);
    cyc(1);
    chk("single_reg_write", 64'(reg_write), 64'd1);
    chk("single_write", 64'(write), 64'd7);
    chk("single_write_data", 64'(write_data), 64'h1);
    chk("single_pending_drain", 64'(pending), 64'd0);
    cyc(1);
    chk("single_pulse_end", 64'(reg_write), 64'd0);
    chk("single_write_hold", 64'(write), 64'd7);

    // simultaneous ALU(2,5) and load(5,C): load first
    alu_valid = 1; alu_dest = 5'd2; alu_data = 32'h5;
    mem_valid = 1; mem_dest = 5'd5; mem_data = 32'hC;
    cyc(1);
    alu_valid = 0; mem_valid = 0;
    chk("both_pending", 64'(pending), 64'd2);
    cyc(1);
    chk("both_first_we", 64'(reg_write), 64'd1);
    chk("both_first_write", 64'(write), 64'd5);
    chk("both_first_data", 64'(write_data), 64'hC);
    cyc(1);
    chk("both_second_we", 64'(reg_write), 64'd1);
    chk("both_second_write", 64'(write), 64'd2);
    chk("both_second_data", 64'(write_data), 64'h5);
    chk("both_pending_drain", 64'(pending), 64'd0);
    cyc(1);
    chk("both_idle", 64'(reg_write), 64'd0);

    // r0 destination is swallowed
    alu_valid = 1; alu_dest = 5'd0; alu_data = 32'hF;
    cyc(1);
    alu_valid = 0;
    chk("r0_pending", 64'(pending), 64'd0);
    cyc(1);
    chk("r0_no_write", 64'(reg_write), 64'd0);
    cyc(1);
    chk("r0_no_write_late", 64'(reg_write), 64'd0);
    chk("r0_write_hold", 64'(write), 64'd2);

    // load streaming with one ALU beat waiting: m,m,m,a,m,m,m
    got_q.delete(); exp_q.delete();
    run_stream(1, 6, 5'd3, 5'd10, 1'b0);
    exp_mem(0, 5'd10); exp_mem(1, 5'd10); exp_mem(2, 5'd10);
    exp_alu(0, 5'd3);
    exp_mem(3, 5'd10); exp_mem(4, 5'd10); exp_mem(5, 5'd10);
    check_writes("starve");

    // ALU back-pressure while loads stream
    got_q.delete(); exp_q.delete();
    run_stream(3, 6, 5'd20, 5'd24, 1'b1);
    exp_mem(0, 5'd24); exp_mem(1, 5'd24); exp_mem(2, 5'd24);
    exp_alu(0, 5'd20);
    exp_mem(3, 5'd24); exp_mem(4, 5'd24); exp_mem(5, 5'd24);
    exp_alu(1, 5'd20); exp_alu(2, 5'd20);
    check_writes("backpressure");

    // mid-operation reset with three beats queued
    alu_valid = 1; alu_dest = 5'd1; alu_data = 32'h11;
    mem_valid = 1; mem_dest = 5'd2; mem_data = 32'h22;
    cyc(1);
    alu_dest = 5'd3; alu_data = 32'h33;
    mem_dest = 5'd4; mem_data = 32'h44;
    cyc(1);
    alu_valid = 0; mem_valid = 0;
    chk("midrst_pending_before", 64'(pending), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_reg_write", 64'(reg_write), 64'd0);
    chk("midrst_write", 64'(write), 64'd0);
    chk("midrst_write_data", 64'(write_data), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_alu_ready", 64'(alu_ready), 64'd0);
    chk("midrst_mem_ready", 64'(mem_ready), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    got_q.delete();
    cyc(10);
    chk("midrst_no_stale_writes", 64'(got_q.size()), 64'd0);
    chk("midrst_pending_after", 64'(pending), 64'd0);
    chk("midrst_alu_ready_after", 64'(alu_ready), 64'd1);
    chk("midrst_mem_ready_after", 64'(mem_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
